// File: rtl/sterownik_kierunku.sv
// Direction controller for the LED chaser: two bouncy buttons are synchronised,
// debounced and edge-detected, and a two-state FSM turns presses into `dir` plus a change strobe.
module sterownik_kierunku #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       zegar,
  input  logic       reset,
  input  logic       btn_lewo,
  input  logic       btn_prawo,
  output logic       dir,
  output logic       dir_zmiana,
  output logic [1:0] przyciski
);

  typedef enum logic {
    LEWO  = 1'b0,
    PRAWO = 1'b1
  } stan_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // Bit 1 is the left button and bit 0 is the right button throughout.
  logic [1:0] btn_raw;
  logic [1:0] deb;
  logic [1:0] deb_prev;
  logic [1:0] press;

  assign btn_raw = {btn_lewo, btn_prawo};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_q;
      logic             s_q;
      logic             deb_q;
      logic             deb_d;
      logic             prev_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Any cycle where the synchronised level agrees with deb restarts the count.
      always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (s_q == deb_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          deb_d = s_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge zegar or negedge reset) begin
        if (!reset) begin
          sync1_q <= 1'b0;
          s_q     <= 1'b0;
          deb_q   <= 1'b0;
          prev_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          s_q     <= sync1_q;
          deb_q   <= deb_d;
          prev_q  <= deb_q;
          cnt_q   <= cnt_d;
        end
      end

      assign deb[gi]      = deb_q;
      assign deb_prev[gi] = prev_q;
    end
  endgenerate

  assign press = deb & ~deb_prev;

  stan_t stan_q;
  logic  dir_zmiana_q;

  // Only an exclusive press of the opposite direction moves the FSM.
  always_ff @(posedge zegar or negedge reset) begin
    if (!reset) begin
      stan_q       <= PRAWO;
      dir_zmiana_q <= 1'b0;
    end else begin
      dir_zmiana_q <= 1'b0;
      case (stan_q)
        PRAWO: begin
          if (press == 2'b10) begin
            stan_q       <= LEWO;
            dir_zmiana_q <= 1'b1;
          end
        end
        LEWO: begin
          if (press == 2'b01) begin
            stan_q       <= PRAWO;
            dir_zmiana_q <= 1'b1;
          end
        end
        default: begin
          stan_q <= PRAWO;
        end
      endcase
    end
  end

  assign dir        = stan_q;
  assign dir_zmiana = dir_zmiana_q;
  assign przyciski  = deb;

endmodule

// File: tb/tb_sterownik_kierunku.sv
// Bench for sterownik_kierunku: directed timing steps plus random button activity,
// all compared against a window-based behavioural model of debounce and direction.
module tb_sterownik_kierunku;

  localparam int DEB = 4;

  logic       zegar;
  logic       reset;
  logic       btn_lewo;
  logic       btn_prawo;
  logic       dir;
  logic       dir_zmiana;
  logic [1:0] przyciski;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;
  int pulses;

  sterownik_kierunku #(
    .DEB_CYCLES(DEB),
    .CNT_W     (3)
  ) dut (
    .zegar     (zegar),
    .reset     (reset),
    .btn_lewo  (btn_lewo),
    .btn_prawo (btn_prawo),
    .dir       (dir),
    .dir_zmiana(dir_zmiana),
    .przyciski (przyciski)
  );

  initial zegar = 1'b0;
  always #5 zegar = ~zegar;

  // Reference model: a debounced level flips once the last DEB synchronised
  // samples all disagree with it; direction follows exclusive rising edges.
  logic [1:0] m_s1, m_s2, m_deb, m_prev, m_press;
  logic       m_dir, m_zm;
  logic [1:0] hist [$];
  bit         differ;

  always @(posedge zegar or negedge reset) begin
    if (!reset) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_deb = 2'b00; m_prev = 2'b00;
      m_dir = 1'b1; m_zm = 1'b0;
      hist.delete();
    end else begin
      m_press = m_deb & ~m_prev;
      m_zm = 1'b0;
      if (m_dir && m_press == 2'b10) begin
        m_dir = 1'b0; m_zm = 1'b1;
      end else if (!m_dir && m_press == 2'b01) begin
        m_dir = 1'b1; m_zm = 1'b1;
      end
      m_prev = m_deb;
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        for (int b = 0; b < 2; b++) begin
          differ = 1;
          foreach (hist[i]) if (hist[i][b] == m_deb[b]) differ = 0;
          if (differ) m_deb[b] = ~m_deb[b];
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn_lewo, btn_prawo};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge zegar) begin
    if (chk_en) begin
      chk("model_dir", dir, m_dir);
      chk("model_dir_zmiana", dir_zmiana, m_zm);
      chk("model_przyciski", przyciski, m_deb);
    end
  end

  task automatic edge1();
    @(posedge zegar);
    #1;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) edge1();
  endtask

  initial begin
    reset = 1'b1; btn_lewo = 1'b0; btn_prawo = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst0_dir", dir, 1'b1);
    chk("rst0_zm", dir_zmiana, 1'b0);
    chk("rst0_btn", przyciski, 2'b00);
    wait_edges(3);
    reset = 1'b1;
    chk_en = 1;
    wait_edges(2);

    // Clean left press
    btn_lewo = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      chk($sformatf("clean_deb_e%0d", k), przyciski[1], k >= 6);
      chk($sformatf("clean_dir_e%0d", k), dir, k < 7);
      chk($sformatf("clean_zm_e%0d", k), dir_zmiana, k == 7);
    end
    pulses = 0;
    repeat (100) begin edge1(); pulses += int'(dir_zmiana); end
    chk("hold_no_pulse", pulses, 0);
    btn_lewo = 1'b0;
    wait_edges(10);
    chk("rel_btn", przyciski, 2'b00);
    chk("rel_dir", dir, 1'b0);

    // Mid-run reset is immediate
    reset = 1'b0;
    #2;
    chk("rst_dir", dir, 1'b1);
    chk("rst_zm", dir_zmiana, 1'b0);
    chk("rst_btn", przyciski, 2'b00);
    wait_edges(2);
    reset = 1'b1;
    wait_edges(3);

    // Bouncing left button
    repeat (2) begin
      btn_lewo = 1'b1;
      repeat (3) begin edge1(); chk("bounce_hi_dir", dir, 1'b1); end
      btn_lewo = 1'b0;
      repeat (2) begin edge1(); chk("bounce_lo_dir", dir, 1'b1); end
    end
    btn_lewo = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge1();
      chk($sformatf("bounce_dir_e%0d", k), dir, k < 7);
    end

    // Left held, right pressed
    wait_edges(5);
    btn_prawo = 1'b1;
    pulses = 0;
    repeat (20) begin edge1(); pulses += int'(dir_zmiana); end
    chk("second_press_pulses", pulses, 1);
    chk("second_press_dir", dir, 1'b1);
    btn_lewo = 1'b0; btn_prawo = 1'b0;
    wait_edges(10);
    chk("both_rel_btn", przyciski, 2'b00);
    chk("both_rel_dir", dir, 1'b1);

    // Redundant right press
    btn_prawo = 1'b1;
    pulses = 0;
    repeat (15) begin edge1(); pulses += int'(dir_zmiana); end
    chk("redundant_pulses", pulses, 0);
    chk("redundant_dir", dir, 1'b1);
    btn_prawo = 1'b0;
    wait_edges(10);

    // Simultaneous presses
    btn_lewo = 1'b1; btn_prawo = 1'b1;
    pulses = 0;
    repeat (15) begin edge1(); pulses += int'(dir_zmiana); end
    chk("simul_pulses", pulses, 0);
    chk("simul_dir", dir, 1'b1);
    chk("simul_btn", przyciski, 2'b11);
    btn_lewo = 1'b0; btn_prawo = 1'b0;
    wait_edges(10);

    // Reset in the middle of a debounce
    btn_lewo = 1'b1;
    wait_edges(3);
    reset = 1'b0;
    #2;
    chk("middeb_rst_dir", dir, 1'b1);
    edge1();
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge1();
      chk($sformatf("middeb_dir_e%0d", k), dir, k < 7);
    end
    btn_lewo = 1'b0;
    wait_edges(10);

    // Random button activity with occasional resets
    repeat (300) begin
      btn_lewo  = 1'($urandom_range(0, 1));
      btn_prawo = 1'($urandom_range(0, 1));
      wait_edges(int'($urandom_range(1, 9)));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        #2;
        chk("rand_rst_dir", dir, 1'b1);
        edge1();
        reset = 1'b1;
      end
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
